// File: rtl/replacement_policy_unit.sv
// Per-set cache victim selection: true LRU, tree PLRU or FIFO, with
// invalid-way preference and a global way-lock mask.
module replacement_policy_unit #(
  parameter int NUM_SETS = 64,
  parameter int ASSOC    = 4,
  parameter int POLICY   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] set,
  input  logic [1:0]                  op,
  input  logic [$clog2(ASSOC)-1:0]    op_way,
  input  logic [ASSOC-1:0]            lock_mask,
  output logic [$clog2(ASSOC)-1:0]    victim_way,
  output logic                        victim_valid,
  output logic                        set_full
);
  localparam int AW = $clog2(ASSOC);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_TOUCH = 2'b01,
    OP_FILL  = 2'b10,
    OP_INV   = 2'b11
  } op_e;

  if (ASSOC < 2 || (ASSOC & (ASSOC - 1)) != 0) begin : g_bad_assoc
    $error("replacement_policy_unit: ASSOC must be a power of 2 >= 2");
  end
  if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_sets
    $error("replacement_policy_unit: NUM_SETS must be a power of 2 >= 2");
  end
  if (POLICY < 0 || POLICY > 2) begin : g_bad_policy
    $error("replacement_policy_unit: POLICY must be 0, 1 or 2");
  end

  logic [ASSOC-1:0] r_valid [NUM_SETS];
  logic [AW-1:0]    w_pol_way;
  logic [AW-1:0]    w_inv_way;
  logic             w_inv_found;

  // NOTE: every entry is reset, not just written on fill, because victim
  // selection reads the state of sets that have never been accessed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
    end else if (op == OP_FILL) begin
      r_valid[set][op_way] <= 1'b1;
    end else if (op == OP_INV) begin
      r_valid[set][op_way] <= 1'b0;
    end
  end

  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    // Descending scan so the lowest-index eligible way wins.
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!r_valid[set][w] && !lock_mask[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = AW'(w);
      end
    end
  end

  assign victim_valid = ~&lock_mask;
  assign set_full     = &r_valid[set];
  assign victim_way   = !victim_valid ? '0 : (w_inv_found ? w_inv_way : w_pol_way);

  if (POLICY == 0) begin : g_lru
    logic [AW-1:0] r_age [NUM_SETS][ASSOC];
    logic          w_recency;
    logic          w_found;
    logic [AW-1:0] w_best_age;
    logic          w_ages_unique;

    assign w_recency = (op == OP_TOUCH) || (op == OP_FILL);

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < ASSOC; w++) r_age[s][w] <= AW'(w);
      end else if (w_recency) begin
        for (int w = 0; w < ASSOC; w++) begin
          if (AW'(w) == op_way) r_age[set][w] <= '0;
          else if (r_age[set][w] < r_age[set][op_way]) r_age[set][w] <= r_age[set][w] + AW'(1);
        end
      end
    end

    // Oldest unlocked way; equals the age==ASSOC-1 way whenever that is unlocked.
    always_comb begin
      w_found    = 1'b0;
      w_best_age = '0;
      w_pol_way  = '0;
      for (int w = 0; w < ASSOC; w++) begin
        if (!lock_mask[w] && (!w_found || r_age[set][w] > w_best_age)) begin
          w_found    = 1'b1;
          w_best_age = r_age[set][w];
          w_pol_way  = AW'(w);
        end
      end
    end

    always_comb begin
      w_ages_unique = 1'b1;
      for (int i = 0; i < ASSOC; i++)
        for (int j = i + 1; j < ASSOC; j++)
          if (r_age[set][i] == r_age[set][j]) w_ages_unique = 1'b0;
    end

    a_ages_unique: assert property (@(posedge clk) disable iff (reset) w_ages_unique);

  end else if (POLICY == 1) begin : g_plru
    logic [ASSOC-2:0] r_tree [NUM_SETS];
    logic             w_recency;
    logic [ASSOC-2:0] w_tree_next;

    assign w_recency = (op == OP_TOUCH) || (op == OP_FILL);

    // Point every node on op_way's path at the sibling subtree.
    always_comb begin : walk_update
      int node;
      node        = 0;
      w_tree_next = r_tree[set];
      for (int l = 0; l < AW; l++) begin
        w_tree_next[node] = ~op_way[AW-1-l];
        node = 2 * node + 1 + int'(op_way[AW-1-l]);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
      end else if (w_recency) begin
        r_tree[set] <= w_tree_next;
      end
    end

    always_comb begin : walk_victim
      int   node;
      int   lo;
      int   half;
      logic lo_locked;
      logic hi_locked;
      logic go_hi;
      node      = 0;
      lo        = 0;
      half      = ASSOC;
      lo_locked = 1'b1;
      hi_locked = 1'b1;
      go_hi     = 1'b0;
      for (int l = 0; l < AW; l++) begin
        half      = half / 2;
        lo_locked = 1'b1;
        hi_locked = 1'b1;
        for (int w = 0; w < ASSOC; w++) begin
          if (w >= lo && w < lo + half && !lock_mask[w]) lo_locked = 1'b0;
          if (w >= lo + half && w < lo + 2 * half && !lock_mask[w]) hi_locked = 1'b0;
        end
        go_hi = r_tree[set][node];
        if (go_hi && hi_locked) go_hi = 1'b0;
        else if (!go_hi && lo_locked) go_hi = 1'b1;
        if (go_hi) lo = lo + half;
        node = 2 * node + 1 + int'(go_hi);
      end
      w_pol_way = AW'(lo);
    end

  end else begin : g_fifo
    logic [AW-1:0] r_ptr [NUM_SETS];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < NUM_SETS; s++) r_ptr[s] <= '0;
      end else if (op == OP_FILL) begin
        r_ptr[set] <= op_way + AW'(1);
      end
    end

    // First unlocked way at or after the pointer, wrapping modulo ASSOC.
    always_comb begin : scan
      logic [AW-1:0] cand;
      logic          found;
      cand      = '0;
      found     = 1'b0;
      w_pol_way = r_ptr[set];
      for (int k = 0; k < ASSOC; k++) begin
        cand = r_ptr[set] + AW'(k);
        if (!found && !lock_mask[cand]) begin
          found     = 1'b1;
          w_pol_way = cand;
        end
      end
    end
  end

  a_victim_unlocked: assert property (@(posedge clk) disable iff (reset)
    victim_valid |-> !lock_mask[victim_way]);
  a_no_x_outputs: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(set) |-> !$isunknown({victim_way, victim_valid, set_full}));

endmodule

// File: tb/tb_replacement_policy_unit.sv
// Table-driven bench: one DUT per policy, each vector drives one op and
// checks the victim/set_full seen after the update via a scoreboard queue.
module tb_replacement_policy_unit;
  localparam int NUM_SETS = 64;
  localparam int ASSOC    = 4;
  localparam int SW       = 6;
  localparam int AW       = 2;
  localparam int LRU = 0, PLRU = 1, FIFO = 2;
  localparam logic [1:0] NONE = 2'b00, TOUCH = 2'b01, FILL = 2'b10, INV = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic [SW-1:0]    set_i  [3];
  logic [1:0]       op_i   [3];
  logic [AW-1:0]    way_i  [3];
  logic [ASSOC-1:0] lock_i [3];
  logic [AW-1:0]    vway   [3];
  logic             vvalid [3];
  logic             sfull  [3];

  always #5 clk = ~clk;

  for (genvar p = 0; p < 3; p++) begin : g_dut
    replacement_policy_unit #(.NUM_SETS(NUM_SETS), .ASSOC(ASSOC), .POLICY(p)) u_dut (
      .clk(clk), .reset(reset), .set(set_i[p]), .op(op_i[p]), .op_way(way_i[p]),
      .lock_mask(lock_i[p]), .victim_way(vway[p]), .victim_valid(vvalid[p]),
      .set_full(sfull[p])
    );
  end

  typedef struct {
    int         pol;
    logic [1:0] op;
    logic [1:0] way;
    logic [5:0] set;
    logic [3:0] lock;
    logic [1:0] e_way;
    logic       e_valid;
    logic       e_full;
    string      name;
  } vec_t;

  typedef struct {
    int         pol;
    logic [1:0] e_way;
    logic       e_valid;
    logic       e_full;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(int pol, logic [1:0] op, logic [1:0] way, logic [5:0] set,
                     logic [3:0] lock, logic [1:0] ew, logic ev, logic ef, string name);
    vec_t v;
    v = '{pol: pol, op: op, way: way, set: set, lock: lock,
          e_way: ew, e_valid: ev, e_full: ef, name: name};
    vecs.push_back(v);
  endtask

  task automatic check(string name, int pol, logic [1:0] aw, logic av, logic af,
                       logic [1:0] ew, logic ev, logic ef);
    n_checks++;
    if (aw !== ew || av !== ev || af !== ef) begin
      n_errors++;
      $display("FAIL %s (policy %0d): got way=%0d valid=%0b full=%0b, expected way=%0d valid=%0b full=%0b",
               name, pol, aw, av, af, ew, ev, ef);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      check(e.name, e.pol, vway[e.pol], vvalid[e.pol], sfull[e.pol], e.e_way, e.e_valid, e.e_full);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    set_i[v.pol]  = v.set;
    op_i[v.pol]   = v.op;
    way_i[v.pol]  = v.way;
    lock_i[v.pol] = v.lock;
    e = '{pol: v.pol, e_way: v.e_way, e_valid: v.e_valid, e_full: v.e_full, name: v.name};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    op_i[v.pol] = NONE;
    compare_next();
  endtask

  initial begin
    exp_t e;
    vec_t v;
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_i[p] = '0; op_i[p] = NONE; way_i[p] = '0; lock_i[p] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int p = 0; p < 3; p++) add(p, NONE, 0, 0, 4'b0000, 0, 1, 0, "reset_state");

    // True LRU
    add(LRU, FILL,  0, 0, 4'b0000, 1, 1, 0, "lru_fill0");
    add(LRU, FILL,  1, 0, 4'b0000, 2, 1, 0, "lru_fill1");
    add(LRU, FILL,  2, 0, 4'b0000, 3, 1, 0, "lru_fill2");
    add(LRU, FILL,  3, 0, 4'b0000, 0, 1, 1, "lru_fill3_full");
    add(LRU, TOUCH, 0, 0, 4'b0000, 1, 1, 1, "lru_touch0");
    add(LRU, TOUCH, 1, 0, 4'b0000, 2, 1, 1, "lru_touch1");
    add(LRU, TOUCH, 3, 0, 4'b0000, 2, 1, 1, "lru_touch3");
    add(LRU, TOUCH, 3, 0, 4'b0000, 2, 1, 1, "lru_touch_mru_again");
    add(LRU, NONE,  0, 5, 4'b0000, 0, 1, 0, "lru_other_set");
    add(LRU, TOUCH, 0, 0, 4'b0000, 2, 1, 1, "lru_seq_t0");
    add(LRU, TOUCH, 1, 0, 4'b0000, 2, 1, 1, "lru_seq_t1");
    add(LRU, TOUCH, 2, 0, 4'b0000, 3, 1, 1, "lru_seq_t2");
    add(LRU, TOUCH, 3, 0, 4'b0000, 0, 1, 1, "lru_seq_t3");
    add(LRU, NONE,  0, 0, 4'b0001, 1, 1, 1, "lru_lock_oldest");
    add(LRU, NONE,  0, 0, 4'b1111, 0, 0, 1, "lru_all_locked");
    add(LRU, NONE,  0, 0, 4'b0000, 0, 1, 1, "lru_unlock");
    add(LRU, INV,   2, 0, 4'b0000, 2, 1, 0, "lru_inv2");
    add(LRU, NONE,  0, 0, 4'b0100, 0, 1, 0, "lru_inv2_locked");
    add(LRU, FILL,  2, 0, 4'b0100, 0, 1, 1, "lru_refill2");
    add(LRU, INV,   1, 0, 4'b0000, 1, 1, 0, "lru_inv1");
    add(LRU, INV,   1, 0, 4'b0000, 1, 1, 0, "lru_inv1_again");
    add(LRU, FILL,  1, 0, 4'b0000, 0, 1, 1, "lru_refill1");
    add(LRU, NONE,  0, 5, 4'b0000, 0, 1, 0, "lru_other_set_end");

    // Tree PLRU
    add(PLRU, FILL,  0, 0, 4'b0000, 1, 1, 0, "plru_fill0");
    add(PLRU, FILL,  1, 0, 4'b0000, 2, 1, 0, "plru_fill1");
    add(PLRU, FILL,  2, 0, 4'b0000, 3, 1, 0, "plru_fill2");
    add(PLRU, FILL,  3, 0, 4'b0000, 0, 1, 1, "plru_fill3_full");
    add(PLRU, TOUCH, 0, 0, 4'b0000, 2, 1, 1, "plru_touch0");
    add(PLRU, TOUCH, 2, 0, 4'b0000, 1, 1, 1, "plru_touch2");
    add(PLRU, NONE,  0, 0, 4'b0010, 0, 1, 1, "plru_leaf_locked");
    add(PLRU, NONE,  0, 0, 4'b0011, 3, 1, 1, "plru_subtree_locked");
    add(PLRU, NONE,  0, 0, 4'b1111, 0, 0, 1, "plru_all_locked");
    add(PLRU, INV,   2, 0, 4'b0000, 2, 1, 0, "plru_inv2");
    add(PLRU, NONE,  0, 0, 4'b0100, 1, 1, 0, "plru_inv2_locked");
    add(PLRU, FILL,  2, 0, 4'b0100, 1, 1, 1, "plru_refill2");
    add(PLRU, NONE,  0, 0, 4'b0000, 1, 1, 1, "plru_unlock");
    add(PLRU, NONE,  0, 5, 4'b0000, 0, 1, 0, "plru_other_set");

    // FIFO
    add(FIFO, FILL,  0, 0, 4'b0000, 1, 1, 0, "fifo_fill0");
    add(FIFO, FILL,  1, 0, 4'b0000, 2, 1, 0, "fifo_fill1");
    add(FIFO, FILL,  2, 0, 4'b0000, 3, 1, 0, "fifo_fill2");
    add(FIFO, FILL,  3, 0, 4'b0000, 0, 1, 1, "fifo_ptr_wrap");
    add(FIFO, FILL,  0, 0, 4'b0000, 1, 1, 1, "fifo_refill0");
    add(FIFO, TOUCH, 3, 0, 4'b0000, 1, 1, 1, "fifo_touch_noeffect");
    add(FIFO, NONE,  0, 0, 4'b0010, 2, 1, 1, "fifo_ptr_locked");
    add(FIFO, NONE,  0, 0, 4'b1110, 0, 1, 1, "fifo_scan_wrap");
    add(FIFO, INV,   2, 0, 4'b0000, 2, 1, 0, "fifo_inv2");
    add(FIFO, NONE,  0, 0, 4'b0100, 1, 1, 0, "fifo_inv2_locked");
    add(FIFO, FILL,  2, 0, 4'b0100, 3, 1, 1, "fifo_refill2");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset together with a fill: reset wins and the fill is discarded.
    @(negedge clk);
    reset     = 1'b1;
    set_i[2]  = 0;
    op_i[2]   = FILL;
    way_i[2]  = 0;
    lock_i[2] = 4'b0000;
    e = '{pol: FIFO, e_way: 0, e_valid: 1, e_full: 0, name: "fifo_reset_with_fill"};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    op_i[2] = NONE;
    reset   = 1'b0;
    compare_next();

    v = '{pol: LRU,  op: NONE, way: 0, set: 0, lock: 4'b0000, e_way: 0, e_valid: 1, e_full: 0, name: "lru_after_reset"};
    apply(v);
    v = '{pol: PLRU, op: NONE, way: 0, set: 0, lock: 4'b0000, e_way: 0, e_valid: 1, e_full: 0, name: "plru_after_reset"};
    apply(v);
    v = '{pol: FIFO, op: FILL, way: 0, set: 0, lock: 4'b0000, e_way: 1, e_valid: 1, e_full: 0, name: "fifo_fill_after_reset"};
    apply(v);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
